// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential BCD subtractor: FSM states and BCD digit constants.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PASS = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int BCD_W     = 4;
    localparam int BCD_MAX   = 9;
    localparam int BCD_RADIX = 10;

    function automatic logic digit_bad(input logic [BCD_W-1:0] x);
        return int'(x) > BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_sub2.sv
// Combinational two-digit BCD subtract stage; borrow ripples from the low digit to the high digit.
module bcd_sub2
    import bcd_pkg::*;
(
    input  logic [2*BCD_W-1:0] a_pair,
    input  logic [2*BCD_W-1:0] b_pair,
    input  logic               bin,
    output logic [2*BCD_W-1:0] d_pair,
    output logic               bout
);

    // Returns {borrow, digit}; a negative raw difference is folded back by one radix.
    function automatic logic [BCD_W:0] sub_digit(input logic [BCD_W-1:0] x,
                                                 input logic [BCD_W-1:0] y,
                                                 input logic             bi);
        logic signed [BCD_W+1:0] t;
        t = $signed({2'b00, x}) - $signed({2'b00, y}) - $signed({{(BCD_W+1){1'b0}}, bi});
        if (t < 0) begin
            t = t + $signed((BCD_W+2)'(BCD_RADIX));
            return {1'b1, t[BCD_W-1:0]};
        end
        return {1'b0, t[BCD_W-1:0]};
    endfunction

    logic [BCD_W:0] lo;
    logic [BCD_W:0] hi;

    assign lo     = sub_digit(a_pair[BCD_W-1:0], b_pair[BCD_W-1:0], bin);
    assign hi     = sub_digit(a_pair[2*BCD_W-1:BCD_W], b_pair[2*BCD_W-1:BCD_W], lo[BCD_W]);
    assign d_pair = {hi[BCD_W-1:0], lo[BCD_W-1:0]};
    assign bout   = hi[BCD_W];

endmodule

// File: rtl/bcd_sub_seq.sv
// Sequential packed-BCD subtractor: one shared two-digit stage processes a digit pair per cycle.
module bcd_sub_seq
    import bcd_pkg::*;
#(
    parameter int NDIG = 4
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [4*NDIG-1:0] a,
    input  logic [4*NDIG-1:0] b,
    input  logic              bin,
    output logic              busy,
    output logic              done,
    output logic [4*NDIG-1:0] d,
    output logic              bout,
    output logic              err
);

    localparam int W      = BCD_W * NDIG;
    localparam int NP     = NDIG / 2;
    localparam int PW     = $clog2(NP) + 1;
    localparam int PAIR_W = 2 * BCD_W;

    function automatic logic word_bad(input logic [W-1:0] x);
        logic f;
        f = 1'b0;
        for (int i = 0; i < NDIG; i++)
            f = f | digit_bad(x[BCD_W*i +: BCD_W]);
        return f;
    endfunction

    state_t          state_q;
    state_t          state_d;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic            bin_q;
    logic [PW-1:0]   p_q;
    logic            brw_q;
    logic [W-1:0]    d_q;
    logic            bout_q;
    logic            err_q;
    logic            busy_q;
    logic            done_q;

    logic            accept;
    logic            ops_bad;
    logic            last_pass;
    logic [PAIR_W-1:0] a_pair;
    logic [PAIR_W-1:0] b_pair;
    logic [PAIR_W-1:0] d_pair;
    logic            stage_bin;
    logic            stage_bout;
    logic [W-1:0]    d_next;

    assign accept    = start && (state_q != PASS);
    assign ops_bad   = word_bad(a_q) | word_bad(b_q);
    assign last_pass = (p_q == PW'(NP - 1));
    assign stage_bin = (p_q == '0) ? bin_q : brw_q;

    always_comb begin
        a_pair = '0;
        b_pair = '0;
        for (int i = 0; i < NP; i++) begin
            if (p_q == PW'(i)) begin
                a_pair = a_q[PAIR_W*i +: PAIR_W];
                b_pair = b_q[PAIR_W*i +: PAIR_W];
            end
        end
    end

    bcd_sub2 u_sub2 (
        .a_pair (a_pair),
        .b_pair (b_pair),
        .bin    (stage_bin),
        .d_pair (d_pair),
        .bout   (stage_bout)
    );

    always_comb begin
        d_next = d_q;
        for (int i = 0; i < NP; i++) begin
            if (p_q == PW'(i))
                d_next[PAIR_W*i +: PAIR_W] = d_pair;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = PASS;
            PASS:    if (ops_bad || last_pass) state_d = DONE;
            DONE:    state_d = start ? PASS : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operands are captured only at accept, so input changes mid-operation are invisible.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q   <= a;
            b_q   <= b;
            bin_q <= bin;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p_q    <= '0;
            brw_q  <= 1'b0;
            d_q    <= '0;
            bout_q <= 1'b0;
            err_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                p_q    <= '0;
                brw_q  <= 1'b0;
                d_q    <= '0;
                bout_q <= 1'b0;
                err_q  <= 1'b0;
                busy_q <= 1'b1;
            end else if (state_q == PASS) begin
                if (ops_bad) begin
                    err_q  <= 1'b1;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end else begin
                    d_q   <= d_next;
                    brw_q <= stage_bout;
                    p_q   <= p_q + PW'(1);
                    if (last_pass) begin
                        bout_q <= stage_bout;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign d    = d_q;
    assign bout = bout_q;
    assign err  = err_q;

endmodule

// File: tb/tb_bcd_sub_seq.sv
// Bench for bcd_sub_seq: directed table, random operands against a decimal-arithmetic model, back-to-back and reset sequences.
`timescale 1ns/1ps
module tb_bcd_sub_seq;

    localparam int NDIG = 4;
    localparam int W    = 4 * NDIG;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] d;
    logic         bout;
    logic         err;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bcd_sub_seq #(.NDIG(NDIG)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .d     (d),
        .bout  (bout),
        .err   (err)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] d;
        logic         bout;
        logic         err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    function automatic int bcd2int(input logic [W-1:0] x);
        int v;
        v = 0;
        for (int i = NDIG - 1; i >= 0; i--)
            v = v * 10 + int'(x[4*i +: 4]);
        return v;
    endfunction

    function automatic logic [W-1:0] int2bcd(input int v);
        logic [W-1:0] r;
        int t;
        r = '0;
        t = v;
        for (int i = 0; i < NDIG; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic has_bad(input logic [W-1:0] x);
        logic f;
        f = 1'b0;
        for (int i = 0; i < NDIG; i++)
            if (x[4*i +: 4] > 4'd9) f = 1'b1;
        return f;
    endfunction

    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin,
                         output logic [W-1:0] ed, output logic eb, output logic ee);
        int diff;
        int modv;
        modv = 1;
        for (int i = 0; i < NDIG; i++) modv = modv * 10;
        ee = has_bad(ma) | has_bad(mb);
        if (ee) begin
            ed = '0;
            eb = 1'b0;
        end else begin
            diff = bcd2int(ma) - bcd2int(mb) - int'(mbin);
            eb   = (diff < 0);
            if (diff < 0) diff = diff + modv;
            ed = int2bcd(diff);
        end
    endtask

    task automatic run_op(input string name, input logic [W-1:0] ai, input logic [W-1:0] bi,
                          input logic bn, input logic [W-1:0] ed, input logic eb, input logic ee);
        int lat;
        @(negedge clk);
        a = ai; b = bi; bin = bn; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
        chk({name, " busy_after_accept"}, 32'(busy), 32'd1);
        lat = 0;
        while (!done && lat < 10) begin
            @(negedge clk);
            lat++;
            if (!done) chk({name, " busy_during"}, 32'(busy), 32'd1);
        end
        chk({name, " latency"}, 32'(lat), ee ? 32'd1 : 32'd2);
        chk({name, " d"}, 32'(d), 32'(ed));
        chk({name, " bout"}, 32'(bout), 32'(eb));
        chk({name, " err"}, 32'(err), 32'(ee));
        chk({name, " busy_at_done"}, 32'(busy), 32'd0);
        @(negedge clk);
        chk({name, " done_one_cycle"}, 32'(done), 32'd0);
        chk({name, " d_hold"}, 32'(d), 32'(ed));
        chk({name, " err_hold"}, 32'(err), 32'(ee));
    endtask

    initial begin
        vec_t         tbl[8];
        logic [W-1:0] ra, rb, ed;
        logic         rbin, eb, ee;
        logic [W-1:0] ops_a[6];
        logic [W-1:0] ops_b[6];
        logic         ops_bin[6];
        int           k;

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;

        tbl[0] = '{16'h4751, 16'h3925, 1'b0, 16'h0826, 1'b0, 1'b0};
        tbl[1] = '{16'h0000, 16'h0001, 1'b0, 16'h9999, 1'b1, 1'b0};
        tbl[2] = '{16'h1000, 16'h0999, 1'b1, 16'h0000, 1'b0, 1'b0};
        tbl[3] = '{16'h12A4, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1};
        tbl[4] = '{16'h9999, 16'h0000, 1'b1, 16'h9998, 1'b0, 1'b0};
        tbl[5] = '{16'h0000, 16'h9999, 1'b1, 16'h0000, 1'b1, 1'b0};
        tbl[6] = '{16'h0500, 16'h0499, 1'b0, 16'h0001, 1'b0, 1'b0};
        tbl[7] = '{16'h0001, 16'h00F0, 1'b0, 16'h0000, 1'b0, 1'b1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset d", 32'(d), 32'd0);
        chk("reset bout", 32'(bout), 32'd0);
        chk("reset err", 32'(err), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++)
            run_op($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].bin,
                   tbl[i].d, tbl[i].bout, tbl[i].err);

        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < NDIG; i++) begin
                ra[4*i +: 4] = 4'($urandom_range(0, 9));
                rb[4*i +: 4] = 4'($urandom_range(0, 9));
            end
            rbin = 1'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                k = int'($urandom_range(0, NDIG - 1));
                if ($urandom_range(0, 1) == 0) ra[4*k +: 4] = 4'($urandom_range(10, 15));
                else                           rb[4*k +: 4] = 4'($urandom_range(10, 15));
            end
            model(ra, rb, rbin, ed, eb, ee);
            run_op($sformatf("rnd%0d", n), ra, rb, rbin, ed, eb, ee);
        end

        // Start held high: each accept should land in the DONE cycle of the previous op.
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < NDIG; j++) begin
                ops_a[i][4*j +: 4] = 4'($urandom_range(0, 9));
                ops_b[i][4*j +: 4] = 4'($urandom_range(0, 9));
            end
            ops_bin[i] = 1'($urandom);
        end
        @(negedge clk);
        a = ops_a[0]; b = ops_b[0]; bin = ops_bin[0]; start = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("b2b%0d busy", i), 32'(busy), 32'd1);
            chk($sformatf("b2b%0d done_early1", i), 32'(done), 32'd0);
            if (i < 5) begin
                a = ops_a[i+1]; b = ops_b[i+1]; bin = ops_bin[i+1];
            end
            @(negedge clk);
            chk($sformatf("b2b%0d done_early2", i), 32'(done), 32'd0);
            @(negedge clk);
            chk($sformatf("b2b%0d done", i), 32'(done), 32'd1);
            model(ops_a[i], ops_b[i], ops_bin[i], ed, eb, ee);
            chk($sformatf("b2b%0d d", i), 32'(d), 32'(ed));
            chk($sformatf("b2b%0d bout", i), 32'(bout), 32'(eb));
        end
        start = 1'b0;
        @(negedge clk);
        chk("b2b idle busy", 32'(busy), 32'd0);
        chk("b2b idle done", 32'(done), 32'd0);

        // Reset at T+1 with start asserted, released for edge T+3.
        @(negedge clk);
        a = 16'h4751; b = 16'h3925; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst d", 32'(d), 32'd0);
        chk("rst bout", 32'(bout), 32'd0);
        chk("rst err", 32'(err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1; start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("rst quiet done%0d", i), 32'(done), 32'd0);
            chk($sformatf("rst quiet busy%0d", i), 32'(busy), 32'd0);
        end
        run_op("post_rst", 16'h4751, 16'h3925, 1'b0, 16'h0826, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
